// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path: off patterns, digit count,
// active-low hex segment table and the snapshot layout.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SEL_OFF = 4'hF;

    // Active-low {g,f,e,d,c,b,a}, indexed by hex value 0..F
    localparam logic [0:15][6:0] HEX_SEG = {
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    // Field order matches the {blank, dig_en, dp, digits} input concatenation
    typedef struct packed {
        logic                         blank;
        logic [NUM_DIGITS-1:0]        dig_en;
        logic [NUM_DIGITS-1:0]        dp;
        logic [NUM_DIGITS-1:0][3:0]   digits;
    } snap_t;

    function automatic logic [NUM_DIGITS-1:0] sel_onehot_n(input logic [1:0] i);
        return ~(4'b0001 << i);
    endfunction

endpackage

// File: rtl/seg_scan4_if.sv
// Display bus: digit data in from the selection logic, pin drives out.
interface seg_scan4_if;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  dig_en;
    logic        blank;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;
    logic        frame_tick;

    modport master (
        output digits, dp, dig_en, blank,
        input  io_sel, io_seg, frame_tick
    );

    modport slave (
        input  digits, dp, dig_en, blank,
        output io_sel, io_seg, frame_tick
    );
endinterface

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-seven-segment decoder, active-low, dp not included.
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[val];
endmodule

// File: rtl/seg_scan4.sv
// Four-digit common-anode scan driver with per-slot blanking gap.
// Optional leading-zero suppression when SEG_LZ_SUPPRESS_EN is defined.
module seg_scan4
    import seg_pkg::*;
#(
    parameter int DIGIT_TICKS = 50000,
    parameter int BLANK_TICKS = 500
)(
    input  logic       clk,
    input  logic       rst_n,
    seg_scan4_if.slave bus
);
    localparam int             CW      = $clog2(DIGIT_TICKS);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0]  CNT_BLK = CW'(BLANK_TICKS);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    snap_t         snap;

    logic slot_end, frame_end, load;
    phase_e phase;

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == 2'd3);
    assign load      = (cnt == '0) && (idx == 2'd0);
    assign phase     = (cnt >= CNT_BLK) ? PH_DRIVE : PH_BLANK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame-coherent copy of the inputs; mid-frame edits wait for the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            snap <= '0;
        else if (load)
            snap <= {bus.blank, bus.dig_en, bus.dp, bus.digits};
    end

    logic [NUM_DIGITS-1:0][6:0] seg_dig;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex7seg_dec u_dec (
            .val (snap.digits[g]),
            .seg (seg_dig[g])
        );
    end

    logic [NUM_DIGITS-1:0] show;

`ifdef SEG_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] supp;
    logic                  hi_off;

    // Walk from the most significant digit; suppression stops at the first
    // enabled non-zero digit, and digit 0 always stays eligible.
    always_comb begin
        supp   = '0;
        hi_off = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            supp[i] = (snap.digits[i] == 4'h0) && hi_off;
            hi_off  = hi_off && (!snap.dig_en[i] || supp[i]);
        end
    end

    assign show = snap.dig_en & ~supp & {NUM_DIGITS{~snap.blank}};
`else
    assign show = snap.dig_en & {NUM_DIGITS{~snap.blank}};
`endif

    logic [3:0] sel_nxt;
    logic [7:0] seg_nxt;

    always_comb begin
        sel_nxt = SEL_OFF;
        seg_nxt = SEG_OFF;
        if (phase == PH_DRIVE && show[idx]) begin
            sel_nxt = sel_onehot_n(idx);
            seg_nxt = {~snap.dp[idx], seg_dig[idx]};
        end
    end

    // Select and segments share one register stage so they switch together,
    // and every digit change passes through an all-off gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.io_sel     <= SEL_OFF;
            bus.io_seg     <= SEG_OFF;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.io_sel     <= sel_nxt;
            bus.io_seg     <= seg_nxt;
            bus.frame_tick <= frame_end;
        end
    end

endmodule
